// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: resolved-branch bundle, redirect kinds and FSM states.
package branch_resolve_unit_pkg;

    localparam int BRU_XLEN         = 32;
    localparam int SQUASH_CNT_WIDTH = 4;

    typedef struct packed {
        logic                valid;
        logic                is_cond;
        logic [BRU_XLEN-1:0] pc;
        logic                taken;
        logic [BRU_XLEN-1:0] target;
        logic                pred_taken;
        logic                next_pc_predicted;
        logic [BRU_XLEN-1:0] pred_next_pc;
    } BranchResolveInfo;

    typedef enum logic [1:0] {
        REDIR_NONE,
        REDIR_MISS,
        REDIR_RELEASE
    } RedirectKind;

    typedef enum logic {
        ST_IDLE,
        ST_SQUASH
    } bru_state_e;

    function automatic logic [BRU_XLEN-1:0] next_seq_pc(input logic [BRU_XLEN-1:0] pc);
        return pc + BRU_XLEN'(4);
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Execute-to-fetch bus of the branch resolve unit; BRU_PERF_CNT_EN adds the perf counter outputs.
interface branch_resolve_unit_if #(parameter int XLEN = 32);

    logic            ex_valid;
    logic            ex_is_cond;
    logic [XLEN-1:0] ex_pc;
    logic            ex_taken;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic            ex_next_pc_predicted;
    logic [XLEN-1:0] ex_pred_next_pc;

    logic            redirect_miss;
    logic [XLEN-1:0] redirect_pc;
    logic            squash;
    logic            pht_upd_valid;
    logic [XLEN-1:0] pht_upd_pc;
    logic            pht_upd_taken;
    logic            btb_wr_valid;
    logic [XLEN-1:0] btb_wr_pc;
    logic [XLEN-1:0] btb_wr_target;
`ifdef BRU_PERF_CNT_EN
    logic [31:0]     perf_resolved;
    logic [31:0]     perf_miss;
`endif

    modport master (
        output ex_valid, ex_is_cond, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_next_pc_predicted, ex_pred_next_pc,
        input  redirect_miss, redirect_pc, squash,
               pht_upd_valid, pht_upd_pc, pht_upd_taken,
               btb_wr_valid, btb_wr_pc, btb_wr_target
`ifdef BRU_PERF_CNT_EN
        , input perf_resolved, perf_miss
`endif
    );

    modport slave (
        input  ex_valid, ex_is_cond, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_next_pc_predicted, ex_pred_next_pc,
        output redirect_miss, redirect_pc, squash,
               pht_upd_valid, pht_upd_pc, pht_upd_taken,
               btb_wr_valid, btb_wr_pc, btb_wr_target
`ifdef BRU_PERF_CNT_EN
        , output perf_resolved, perf_miss
`endif
    );

endinterface

// File: rtl/branch_resolve_unit_classify.sv
// bru_classify: combinational resolution of one branch into actual direction, correct PC and redirect kind.
module bru_classify
    import branch_resolve_unit_pkg::*;
(
    input  BranchResolveInfo    info,
    output logic                actual_taken,
    output logic [BRU_XLEN-1:0] correct_pc,
    output RedirectKind         kind
);

    always_comb begin
        actual_taken = info.is_cond ? info.taken : 1'b1;
        correct_pc   = actual_taken ? info.target : next_seq_pc(info.pc);
        kind         = REDIR_NONE;
        // A missing prediction with pred_taken set means fetch is stalled on us, so nothing needs squashing.
        if ((info.next_pc_predicted && (info.pred_next_pc != correct_pc)) ||
            (!info.next_pc_predicted && !info.pred_taken && actual_taken)) begin
            kind = REDIR_MISS;
        end else if (!info.next_pc_predicted && info.pred_taken) begin
            kind = REDIR_RELEASE;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: redirects fetch, trains PHT/BTB and squashes wrong-path results after a miss.
// Optional perf counters are enabled with `define BRU_PERF_CNT_EN.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int XLEN          = BRU_XLEN,
    parameter int SQUASH_CYCLES = 2
) (
    input logic                 clk,
    input logic                 rst,
    branch_resolve_unit_if.slave bus
);

    localparam logic [SQUASH_CNT_WIDTH-1:0] SQUASH_INIT = SQUASH_CNT_WIDTH'(SQUASH_CYCLES);

    BranchResolveInfo            info;
    logic                        actual_taken;
    logic [BRU_XLEN-1:0]         correct_pc;
    RedirectKind                 kind;

    bru_state_e                  state_q, state_d;
    logic [SQUASH_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                        accept;

    logic                        redirect_miss_q, redirect_miss_d;
    logic [XLEN-1:0]             redirect_pc_q, redirect_pc_d;
    logic                        pht_valid_q, pht_valid_d;
    logic [XLEN-1:0]             pht_pc_q, pht_pc_d;
    logic                        pht_taken_q, pht_taken_d;
    logic                        btb_valid_q, btb_valid_d;
    logic [XLEN-1:0]             btb_pc_q, btb_pc_d;
    logic [XLEN-1:0]             btb_target_q, btb_target_d;

    assign info = '{
        valid:             bus.ex_valid,
        is_cond:           bus.ex_is_cond,
        pc:                bus.ex_pc,
        taken:             bus.ex_taken,
        target:            bus.ex_target,
        pred_taken:        bus.ex_pred_taken,
        next_pc_predicted: bus.ex_next_pc_predicted,
        pred_next_pc:      bus.ex_pred_next_pc
    };

    bru_classify u_classify (
        .info         (info),
        .actual_taken (actual_taken),
        .correct_pc   (correct_pc),
        .kind         (kind)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            redirect_miss_q <= 1'b0;
            redirect_pc_q   <= '0;
            pht_valid_q     <= 1'b0;
            pht_pc_q        <= '0;
            pht_taken_q     <= 1'b0;
            btb_valid_q     <= 1'b0;
            btb_pc_q        <= '0;
            btb_target_q    <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            redirect_miss_q <= redirect_miss_d;
            redirect_pc_q   <= redirect_pc_d;
            pht_valid_q     <= pht_valid_d;
            pht_pc_q        <= pht_pc_d;
            pht_taken_q     <= pht_taken_d;
            btb_valid_q     <= btb_valid_d;
            btb_pc_q        <= btb_pc_d;
            btb_target_q    <= btb_target_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        accept          = 1'b0;
        redirect_miss_d = 1'b0;
        redirect_pc_d   = '0;
        pht_valid_d     = 1'b0;
        pht_pc_d        = '0;
        pht_taken_d     = 1'b0;
        btb_valid_d     = 1'b0;
        btb_pc_d        = '0;
        btb_target_d    = '0;

        case (state_q)
            ST_IDLE: begin
                accept = info.valid;
                if (accept) begin
                    if (kind == REDIR_MISS) begin
                        redirect_miss_d = 1'b1;
                        redirect_pc_d   = correct_pc;
                        state_d         = ST_SQUASH;
                        cnt_d           = SQUASH_INIT;
                    end else if (kind == REDIR_RELEASE) begin
                        redirect_pc_d   = correct_pc;
                    end
                    if (info.is_cond) begin
                        pht_valid_d = 1'b1;
                        pht_pc_d    = info.pc;
                        pht_taken_d = actual_taken;
                    end
                    if (actual_taken && (!info.next_pc_predicted || (info.pred_next_pc != info.target))) begin
                        btb_valid_d  = 1'b1;
                        btb_pc_d     = info.pc;
                        btb_target_d = info.target;
                    end
                end
            end
            ST_SQUASH: begin
                // The last squash cycle is the one where the counter drops to zero.
                cnt_d = cnt_q - SQUASH_CNT_WIDTH'(1);
                if (cnt_q <= SQUASH_CNT_WIDTH'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.redirect_miss = redirect_miss_q;
    assign bus.redirect_pc   = redirect_pc_q;
    assign bus.squash        = (state_q == ST_SQUASH);
    assign bus.pht_upd_valid = pht_valid_q;
    assign bus.pht_upd_pc    = pht_pc_q;
    assign bus.pht_upd_taken = pht_taken_q;
    assign bus.btb_wr_valid  = btb_valid_q;
    assign bus.btb_wr_pc     = btb_pc_q;
    assign bus.btb_wr_target = btb_target_q;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_resolved_q;
    logic [31:0] perf_miss_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_resolved_q <= '0;
            perf_miss_q     <= '0;
        end else begin
            if (accept) begin
                perf_resolved_q <= perf_resolved_q + 32'd1;
            end
            if (accept && (kind == REDIR_MISS)) begin
                perf_miss_q <= perf_miss_q + 32'd1;
            end
        end
    end

    assign bus.perf_resolved = perf_resolved_q;
    assign bus.perf_miss     = perf_miss_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed vector table, reset-in-squash sequence and random stimulus vs. a reference model.
module tb_branch_resolve_unit;

    localparam int SQUASH_CYCLES = 2;

    typedef struct packed {
        logic        valid;
        logic        is_cond;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
        logic        pred_taken;
        logic        npp;
        logic [31:0] pred_next;
    } in_t;

    typedef struct packed {
        logic        miss;
        logic [31:0] rpc;
        logic        squash;
        logic        pht_v;
        logic [31:0] pht_pc;
        logic        pht_taken;
        logic        btb_v;
        logic [31:0] btb_pc;
        logic [31:0] btb_target;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int   vectors_applied = 0;
    int   miscompares     = 0;
    int   blocked         = 0;
    int   ref_resolved    = 0;
    int   ref_miss        = 0;
    in_t  cur_in          = '0;
    out_t model_exp       = '0;

    branch_resolve_unit_if #(.XLEN(32)) bus ();

    branch_resolve_unit #(.XLEN(32), .SQUASH_CYCLES(SQUASH_CYCLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic in_t mk_in(logic v, logic c, logic [31:0] pc, logic t, logic [31:0] tgt,
                                  logic pt, logic npp, logic [31:0] pn);
        in_t r;
        r = '{valid: v, is_cond: c, pc: pc, taken: t, target: tgt, pred_taken: pt, npp: npp, pred_next: pn};
        return r;
    endfunction

    function automatic out_t mk_out(logic m, logic [31:0] rpc, logic sq, logic pv, logic [31:0] ppc,
                                    logic ptk, logic bv, logic [31:0] bpc, logic [31:0] bt);
        out_t r;
        r = '{miss: m, rpc: rpc, squash: sq, pht_v: pv, pht_pc: ppc, pht_taken: ptk,
              btb_v: bv, btb_pc: bpc, btb_target: bt};
        return r;
    endfunction

    // Reference: the address fetch should have gone to, and whether fetch must be told about it.
    function automatic logic [31:0] ref_correct_pc(in_t v);
        logic went;
        went = v.is_cond ? v.taken : 1'b1;
        return went ? v.target : v.pc + 32'd4;
    endfunction

    function automatic bit ref_went(in_t v);
        return v.is_cond ? v.taken : 1'b1;
    endfunction

    function automatic bit ref_is_miss(in_t v);
        if (v.npp) return v.pred_next != ref_correct_pc(v);
        return !v.pred_taken && ref_went(v);
    endfunction

    function automatic bit ref_is_release(in_t v);
        return !v.npp && v.pred_taken;
    endfunction

    function automatic out_t model_cycle(in_t v);
        out_t o;
        bit   accepted;
        o        = '0;
        accepted = v.valid && (blocked == 0);
        if (blocked > 0) blocked--;
        if (accepted) begin
            ref_resolved++;
            if (ref_is_miss(v)) begin
                ref_miss++;
                o.miss  = 1'b1;
                o.rpc   = ref_correct_pc(v);
                blocked = SQUASH_CYCLES;
            end else if (ref_is_release(v)) begin
                o.rpc = ref_correct_pc(v);
            end
            if (v.is_cond) begin
                o.pht_v     = 1'b1;
                o.pht_pc    = v.pc;
                o.pht_taken = v.taken;
            end
            if (ref_went(v) && (!v.npp || v.pred_next != v.target)) begin
                o.btb_v      = 1'b1;
                o.btb_pc     = v.pc;
                o.btb_target = v.target;
            end
        end
        o.squash = (blocked > 0);
        return o;
    endfunction

    // Fetch cannot observe a release to address zero; treat any such stimulus as fatal.
    always @(posedge clk) begin
        if (!rst && cur_in.valid && !bus.squash) begin
            assert (!(ref_is_release(cur_in) && !ref_is_miss(cur_in) && ref_correct_pc(cur_in) == 32'd0))
            else $fatal(1, "[TB] FAIL release_to_zero pc=%h", cur_in.pc);
        end
    end

    task automatic applyStimulus(input in_t v);
        cur_in                   = v;
        bus.ex_valid             = v.valid;
        bus.ex_is_cond           = v.is_cond;
        bus.ex_pc                = v.pc;
        bus.ex_taken             = v.taken;
        bus.ex_target            = v.target;
        bus.ex_pred_taken        = v.pred_taken;
        bus.ex_next_pc_predicted = v.npp;
        bus.ex_pred_next_pc      = v.pred_next;
        @(posedge clk);
        model_exp = model_cycle(v);
        #1;
    endtask

    task automatic checkOutput(input string name, input out_t exp);
        out_t act;
        act = '{miss: bus.redirect_miss, rpc: bus.redirect_pc, squash: bus.squash,
                pht_v: bus.pht_upd_valid, pht_pc: bus.pht_upd_pc, pht_taken: bus.pht_upd_taken,
                btb_v: bus.btb_wr_valid, btb_pc: bus.btb_wr_pc, btb_target: bus.btb_wr_target};
        vectors_applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got miss=%b rpc=%h sq=%b pht=%b/%h/%b btb=%b/%h/%h, want miss=%b rpc=%h sq=%b pht=%b/%h/%b btb=%b/%h/%h",
                     name, act.miss, act.rpc, act.squash, act.pht_v, act.pht_pc, act.pht_taken,
                     act.btb_v, act.btb_pc, act.btb_target,
                     exp.miss, exp.rpc, exp.squash, exp.pht_v, exp.pht_pc, exp.pht_taken,
                     exp.btb_v, exp.btb_pc, exp.btb_target);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors_applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        cur_in = '0;
        applyIdleInputs();
        blocked      = 0;
        ref_resolved = 0;
        ref_miss     = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic applyIdleInputs();
        bus.ex_valid             = 1'b0;
        bus.ex_is_cond           = 1'b0;
        bus.ex_pc                = '0;
        bus.ex_taken             = 1'b0;
        bus.ex_target            = '0;
        bus.ex_pred_taken        = 1'b0;
        bus.ex_next_pc_predicted = 1'b0;
        bus.ex_pred_next_pc      = '0;
    endtask

    vec_t vecs[14];
    in_t  idle_in;

    initial begin
        idle_in = '0;
        applyIdleInputs();
        #1;
        checkOutput("reset_state", '0);
        doReset();

        vecs[0]  = '{mk_in(1, 1, 32'h100, 0, 32'h900, 0, 0, 0),
                     mk_out(0, 0, 0, 1, 32'h100, 0, 0, 0, 0)};
        vecs[1]  = '{mk_in(1, 1, 32'h120, 1, 32'h200, 0, 0, 0),
                     mk_out(1, 32'h200, 1, 1, 32'h120, 1, 1, 32'h120, 32'h200)};
        vecs[2]  = '{mk_in(1, 1, 32'h124, 1, 32'h260, 0, 0, 0),
                     mk_out(0, 0, 1, 0, 0, 0, 0, 0, 0)};
        vecs[3]  = '{mk_in(1, 1, 32'h128, 1, 32'h260, 0, 0, 0),
                     mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[4]  = '{mk_in(1, 1, 32'h140, 0, 32'h999, 0, 0, 0),
                     mk_out(0, 0, 0, 1, 32'h140, 0, 0, 0, 0)};
        vecs[5]  = '{mk_in(1, 0, 32'h180, 0, 32'h40, 1, 0, 0),
                     mk_out(0, 32'h40, 0, 0, 0, 0, 1, 32'h180, 32'h40)};
        vecs[6]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0),
                     mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[7]  = '{mk_in(1, 0, 32'h1C0, 0, 32'h304, 1, 1, 32'h300),
                     mk_out(1, 32'h304, 1, 0, 0, 0, 1, 32'h1C0, 32'h304)};
        vecs[8]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0),
                     mk_out(0, 0, 1, 0, 0, 0, 0, 0, 0)};
        vecs[9]  = '{mk_in(0, 0, 0, 0, 0, 0, 0, 0),
                     mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        vecs[10] = '{mk_in(1, 1, 32'h200, 1, 32'h500, 1, 1, 32'h500),
                     mk_out(0, 0, 0, 1, 32'h200, 1, 0, 0, 0)};
        vecs[11] = '{mk_in(1, 1, 32'h204, 1, 32'h600, 1, 1, 32'h600),
                     mk_out(0, 0, 0, 1, 32'h204, 1, 0, 0, 0)};
        vecs[12] = '{mk_in(1, 1, 32'h208, 1, 32'h700, 1, 1, 32'h700),
                     mk_out(0, 0, 0, 1, 32'h208, 1, 0, 0, 0)};
        vecs[13] = '{mk_in(1, 1, 32'h20C, 0, 32'h800, 0, 1, 32'h210),
                     mk_out(0, 0, 0, 1, 32'h20C, 0, 0, 0, 0)};

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].in);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Async reset on the first squash cycle drops the redirect and the squash window at once.
        applyStimulus(mk_in(1, 1, 32'h300, 1, 32'h400, 0, 0, 0));
        checkOutput("rst_seq_miss", mk_out(1, 32'h400, 1, 1, 32'h300, 1, 1, 32'h300, 32'h400));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_clear", '0);
        blocked = 0;
        #2;
        rst = 1'b0;
        applyStimulus(mk_in(1, 0, 32'h310, 0, 32'h80, 1, 0, 0));
        checkOutput("rst_after_release", mk_out(0, 32'h80, 0, 0, 0, 0, 1, 32'h310, 32'h80));
        applyStimulus(idle_in);
        checkOutput("rst_after_idle", '0);

        for (int n = 0; n < 400; n++) begin
            in_t         v;
            logic [31:0] cpc;
            v.valid      = ($urandom_range(0, 3) != 0);
            v.is_cond    = $urandom_range(0, 2) != 0;
            v.pc         = 32'($urandom_range(1, 4000)) << 2;
            v.taken      = $urandom_range(0, 1) == 1;
            v.target     = 32'($urandom_range(1, 4000)) << 2;
            v.pred_taken = $urandom_range(0, 1) == 1;
            v.npp        = $urandom_range(0, 1) == 1;
            cpc          = ref_correct_pc(v);
            case ($urandom_range(0, 3))
                0:       v.pred_next = cpc;
                1:       v.pred_next = v.target;
                2:       v.pred_next = v.pc + 32'd4;
                default: v.pred_next = 32'($urandom_range(1, 4000)) << 2;
            endcase
            applyStimulus(v);
            checkOutput($sformatf("rand%0d", n), model_exp);
        end

`ifdef BRU_PERF_CNT_EN
        doReset();
        applyStimulus(mk_in(1, 1, 32'h100, 0, 32'h900, 0, 0, 0));
        checkOutput("perf_none0", model_exp);
        applyStimulus(mk_in(1, 1, 32'h104, 1, 32'h200, 0, 0, 0));
        checkOutput("perf_miss0", model_exp);
        repeat (2) begin
            applyStimulus(idle_in);
            checkOutput("perf_squash", model_exp);
        end
        applyStimulus(mk_in(1, 1, 32'h200, 0, 32'h900, 0, 0, 0));
        checkOutput("perf_none1", model_exp);
        applyStimulus(mk_in(1, 0, 32'h204, 0, 32'h600, 0, 1, 32'h608));
        checkOutput("perf_miss1", model_exp);
        repeat (2) begin
            applyStimulus(idle_in);
            checkOutput("perf_squash", model_exp);
        end
        applyStimulus(mk_in(1, 0, 32'h600, 0, 32'h40, 1, 0, 0));
        checkOutput("perf_release", model_exp);
        checkValue("perf_resolved", bus.perf_resolved, 32'd5);
        checkValue("perf_miss", bus.perf_miss, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
